vga_scandoubler_gen: RTL and testbench



---
 rtl/vga_scandoubler_gen.sv | 183 ++++++++++++++++++
 tb/tb_vga_scandoubler_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scandoubler_gen.sv
// rtl/vga_scandoubler_gen.sv - 15 kHz to 31 kHz line doubler with scanlines, DE and vsync regeneration
// Scanline dimming is built only when SCANDBL_DIM_EN is defined.
module vga_scandoubler_gen #(
  parameter int CW          = 3,
  parameter int LINE_AW     = 10,
  parameter int MIN_LINE    = 128,
  parameter int HSYNC_LEN   = 94,
  parameter int VSYNC_LEN   = 3200,
  parameter int H_ACT_START = 112,
  parameter int H_ACT       = 704,
  parameter int V_ACT_START = 40,
  parameter int V_ACT       = 568
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce_in,
  input  logic               enable,
  input  logic [1:0]         dim_level,
  input  logic [CW-1:0]      r_in,
  input  logic [CW-1:0]      g_in,
  input  logic [CW-1:0]      b_in,
  input  logic               hsync_in_n,
  input  logic               vsync_in_n,
  input  logic               csync_in_n,
  output logic [CW-1:0]      r_out,
  output logic [CW-1:0]      g_out,
  output logic [CW-1:0]      b_out,
  output logic               hsync_out_n,
  output logic               vsync_out_n,
  output logic               de,
  output logic [LINE_AW-1:0] line_len
);

  localparam int PW = 3 * CW;
  localparam int VW = $clog2(VSYNC_LEN + 1);
  localparam logic [LINE_AW-1:0] WR_MAX  = '1;
  localparam logic [LINE_AW-1:0] MIN_L   = LINE_AW'(MIN_LINE);
  localparam logic [LINE_AW-1:0] HS_END  = LINE_AW'(HSYNC_LEN);
  localparam logic [LINE_AW:0]   H_LO    = (LINE_AW+1)'(H_ACT_START);
  localparam logic [LINE_AW:0]   H_HI    = (LINE_AW+1)'(H_ACT_START + H_ACT);
  localparam logic [11:0]        V_LO    = 12'(V_ACT_START);
  localparam logic [11:0]        V_HI    = 12'(V_ACT_START + V_ACT);
  localparam logic [VW-1:0]      VS_LOAD = VW'(VSYNC_LEN);

  logic [PW-1:0]      mem [2**(LINE_AW+1)];
  logic [PW-1:0]      rd_data;
  logic [PW-1:0]      pix_col;
  logic [LINE_AW-1:0] wr_cnt;
  logic [LINE_AW-1:0] rd_cnt;
  logic [11:0]        vline;
  logic [VW-1:0]      vs_cnt;
  logic [VW-1:0]      vs_cnt_nxt;
  logic               wr_bank;
  logic               pass;
  logic               pass_d;
  logic               hs_r;
  logic               hs_prev;
  logic               vs_q;
  logic               line_ok;
  logic               hs_d;
  logic               de_d;
  logic               swap;
  logic               rd_wrap;
  logic               vs_fall;
  logic               h_act;
  logic               v_act;

  // Edge seen between two pixel strobes; short lines are treated as glitches.
  assign swap    = ce_in && hs_prev && !hs_r && (wr_cnt >= MIN_L);
  assign rd_wrap = (rd_cnt == line_len);
  assign vs_fall = vs_q && !vsync_in_n;
  assign h_act   = ({1'b0, rd_cnt} >= H_LO) && ({1'b0, rd_cnt} < H_HI);
  assign v_act   = (vline >= V_LO) && (vline < V_HI);

  always_comb begin
    vs_cnt_nxt = vs_cnt;
    if (vs_fall)
      vs_cnt_nxt = VS_LOAD;
    else if (vs_cnt != '0)
      vs_cnt_nxt = vs_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ce_in)
      mem[{wr_bank, wr_cnt}] <= {r_in, g_in, b_in};
    rd_data <= mem[{~wr_bank, rd_cnt}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r     <= 1'b1;
      hs_prev  <= 1'b1;
      vs_q     <= 1'b1;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      line_len <= '1;
      rd_cnt   <= '0;
      pass     <= 1'b0;
      line_ok  <= 1'b0;
      vline    <= '0;
      vs_cnt   <= '0;
      pass_d   <= 1'b0;
      hs_d     <= 1'b1;
      de_d     <= 1'b0;
    end else begin
      hs_r   <= hsync_in_n;
      vs_q   <= vsync_in_n;
      vs_cnt <= vs_cnt_nxt;
      // The strobe carrying the edge closes the old line, so its count is wr_cnt+1 pixels.
      if (ce_in) begin
        hs_prev <= hs_r;
        if (swap) begin
          line_len <= wr_cnt;
          wr_bank  <= ~wr_bank;
          wr_cnt   <= '0;
        end else if (wr_cnt != WR_MAX) begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (swap) begin
        rd_cnt  <= '0;
        pass    <= 1'b0;
        line_ok <= 1'b1;
      end else if (rd_wrap) begin
        rd_cnt <= '0;
        pass   <= ~pass;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (vs_fall)
        vline <= '0;
      else if ((swap || rd_wrap) && vline != 12'hFFF)
        vline <= vline + 1'b1;
      pass_d <= pass;
      hs_d   <= (rd_cnt >= HS_END);
      de_d   <= h_act && v_act;
    end
  end

`ifdef SCANDBL_DIM_EN
  function automatic logic [CW-1:0] dim_ch(input logic [CW-1:0] c, input logic [1:0] lvl);
    case (lvl)
      2'd1:    return c - (c >> 2);
      2'd2:    return c >> 1;
      2'd3:    return c >> 2;
      default: return c;
    endcase
  endfunction

  always_comb begin
    pix_col = rd_data;
    if (pass_d)
      pix_col = {dim_ch(rd_data[PW-1 -: CW], dim_level),
                 dim_ch(rd_data[2*CW-1 -: CW], dim_level),
                 dim_ch(rd_data[CW-1:0], dim_level)};
  end
`else
  logic unused_dim;
  assign unused_dim = ^{dim_level, pass_d};
  assign pix_col    = rd_data;
`endif

  // Until the first accepted line lands in a bank the read side has nothing valid to show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_out, g_out, b_out} <= '0;
      hsync_out_n           <= 1'b1;
      vsync_out_n           <= 1'b1;
      de                    <= 1'b0;
    end else if (enable) begin
      {r_out, g_out, b_out} <= line_ok ? pix_col : '0;
      hsync_out_n           <= hs_d;
      vsync_out_n           <= (vs_cnt_nxt == '0);
      de                    <= de_d;
    end else begin
      {r_out, g_out, b_out} <= {r_in, g_in, b_in};
      hsync_out_n           <= csync_in_n;
      vsync_out_n           <= 1'b1;
      de                    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_scandoubler_gen.sv
// tb/tb_vga_scandoubler_gen.sv - directed bench for vga_scandoubler_gen (896-clk input lines)
module tb_vga_scandoubler_gen;

  localparam int CW = 3;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_in;
  logic          enable;
  logic [1:0]    dim_level;
  logic [CW-1:0] r_in, g_in, b_in;
  logic          hsync_in_n, vsync_in_n, csync_in_n;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hsync_out_n, vsync_out_n, de;
  logic [AW-1:0] line_len;

  int checks   = 0;
  int failures = 0;
  int hcnt     = 0;
  logic glitch_en = 1'b0;
  logic var_pix   = 1'b0;

  vga_scandoubler_gen dut (
    .clk(clk), .rst_n(rst_n), .ce_in(ce_in), .enable(enable), .dim_level(dim_level),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in_n(hsync_in_n), .vsync_in_n(vsync_in_n), .csync_in_n(csync_in_n),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out_n(hsync_out_n), .vsync_out_n(vsync_out_n), .de(de), .line_len(line_len)
  );

  always #5 clk = ~clk;

  // Source: 448 pixels per line, ce every 2nd clk, hsync low for the first 64 clks.
  initial begin
    ce_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    hsync_in_n = 1'b1; csync_in_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      hcnt       = (hcnt == 895) ? 0 : hcnt + 1;
      ce_in      = (hcnt % 2 == 0);
      hsync_in_n = !(hcnt < 64 || (glitch_en && hcnt >= 100 && hcnt < 104));
      csync_in_n = var_pix ? hcnt[2] : hsync_in_n;
      r_in       = var_pix ? hcnt[2:0] : 3'd7;
      g_in       = var_pix ? hcnt[3:1] : 3'd7;
      b_in       = 3'd7;
    end
  end

  task automatic wait_line_start();
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (hcnt == 0) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL line_start_timeout: got no line start, required one within 1000 clks");
    end
  endtask

  task automatic measure_hs(output int per, output int low);
    logic prev;
    int t;
    bit seen = 0;
    per = -1; low = 0; prev = hsync_out_n;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (prev && !hsync_out_n) seen = 1;
      prev = hsync_out_n;
    end
    if (seen) begin
      low = 1; t = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        t++;
        if (!hsync_out_n && low == t) low++;
        if (prev && !hsync_out_n) begin
          per = t;
          break;
        end
        prev = hsync_out_n;
      end
    end
  endtask

  task automatic count_falls(input int n, output int cnt);
    logic prev = hsync_out_n;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (prev && !hsync_out_n) cnt++;
      prev = hsync_out_n;
    end
  endtask

  task automatic sample_pair(output logic [3*CW-1:0] c0, output logic [3*CW-1:0] c1);
    wait_line_start();
    repeat (200) @(negedge clk);
    c0 = {r_out, g_out, b_out};
    repeat (448) @(negedge clk);
    c1 = {r_out, g_out, b_out};
  endtask

  function automatic logic [CW-1:0] dim7(input int lvl);
`ifdef SCANDBL_DIM_EN
    case (lvl)
      1:       return 3'd6;
      2:       return 3'd3;
      3:       return 3'd1;
      default: return 3'd7;
    endcase
`else
    return (lvl >= 0) ? 3'd7 : 3'd0;
`endif
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({r_out, g_out, b_out} !== '0) begin failures++; $display("FAIL reset_colour: got %h expected 0", {r_out, g_out, b_out}); end
    checks++; if (hsync_out_n !== 1'b1) begin failures++; $display("FAIL reset_hsync: got %b expected 1", hsync_out_n); end
    checks++; if (vsync_out_n !== 1'b1) begin failures++; $display("FAIL reset_vsync: got %b expected 1", vsync_out_n); end
    checks++; if (de !== 1'b0) begin failures++; $display("FAIL reset_de: got %b expected 0", de); end
    checks++; if (line_len !== 10'h3FF) begin failures++; $display("FAIL reset_line_len: got %0d expected 1023", line_len); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({r_out, g_out, b_out} !== '0) begin failures++; $display("FAIL pre_swap_colour: got %h expected 0", {r_out, g_out, b_out}); end
  endtask

  task automatic test_line_timing();
    int per, low, n;
    repeat (3 * 896) @(negedge clk);
    checks++; if (line_len !== 10'd447) begin failures++; $display("FAIL line_len: got %0d expected 447", line_len); end
    measure_hs(per, low);
    checks++; if (per != 448) begin failures++; $display("FAIL hs_period: got %0d expected 448", per); end
    checks++; if (low != 94) begin failures++; $display("FAIL hs_low: got %0d expected 94", low); end
    count_falls(4 * 896, n);
    checks++; if (n != 8) begin failures++; $display("FAIL hs_per_4_in_lines: got %0d expected 8", n); end
  endtask

  task automatic test_glitch();
    int per, low, n;
    glitch_en = 1'b1;
    repeat (2 * 896) @(negedge clk);
    checks++; if (line_len !== 10'd447) begin failures++; $display("FAIL glitch_line_len: got %0d expected 447", line_len); end
    count_falls(4 * 896, n);
    checks++; if (n != 8) begin failures++; $display("FAIL glitch_hs_count: got %0d expected 8", n); end
    measure_hs(per, low);
    checks++; if (per != 448) begin failures++; $display("FAIL glitch_hs_period: got %0d expected 448", per); end
    glitch_en = 1'b0;
  endtask

  task automatic test_dim();
    logic [3*CW-1:0] c0, c1;
    for (int lvl = 0; lvl < 4; lvl++) begin
      dim_level = 2'(lvl);
      sample_pair(c0, c1);
      checks++; if (c0 !== 9'h1FF) begin failures++; $display("FAIL dim%0d_pass0: got %h expected 1ff", lvl, c0); end
      checks++; if (c1 !== {3{dim7(lvl)}}) begin failures++; $display("FAIL dim%0d_pass1: got %h expected %h", lvl, c1, {3{dim7(lvl)}}); end
    end
    dim_level = 2'd0;
  endtask

  task automatic test_vsync();
    int lowc;
    @(negedge clk);
    vsync_in_n = 1'b0; lowc = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (!vsync_out_n) lowc++;
      if (i == 1) begin
        checks++; if (vsync_out_n !== 1'b0) begin failures++; $display("FAIL vs_latency: got %b expected 0", vsync_out_n); end
      end
      if (i == 10) vsync_in_n = 1'b1;
      if (i > 20 && vsync_out_n) break;
    end
    checks++; if (lowc != 3200) begin failures++; $display("FAIL vs_width: got %0d expected 3200", lowc); end
    repeat (20) @(negedge clk);
    vsync_in_n = 1'b0; lowc = 0;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      if (!vsync_out_n) lowc++;
      if (i == 10) vsync_in_n = 1'b1;
      if (i == 1000) vsync_in_n = 1'b0;
      if (i == 1010) vsync_in_n = 1'b1;
      if (i > 1020 && vsync_out_n) break;
    end
    checks++; if (lowc != 4200) begin failures++; $display("FAIL vs_restart_width: got %0d expected 4200", lowc); end
  endtask

  task automatic test_de();
    wait_line_start();
    repeat (300) @(negedge clk);
    checks++; if (de !== 1'b0) begin failures++; $display("FAIL de_vblank: got %b expected 0", de); end
    repeat (45 * 448) @(negedge clk);
    wait_line_start();
    repeat (300) @(negedge clk);
    checks++; if (de !== 1'b1) begin failures++; $display("FAIL de_active: got %b expected 1", de); end
    wait_line_start();
    repeat (50) @(negedge clk);
    checks++; if (de !== 1'b0) begin failures++; $display("FAIL de_hblank: got %b expected 0", de); end
  endtask

  task automatic test_reset_midline();
    logic [3*CW-1:0] c0, c1;
    dim_level = 2'd2;
    wait_line_start();
    repeat (305) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({r_out, g_out, b_out} !== '0) begin failures++; $display("FAIL mid_reset_colour: got %h expected 0", {r_out, g_out, b_out}); end
    checks++; if (hsync_out_n !== 1'b1 || vsync_out_n !== 1'b1) begin failures++; $display("FAIL mid_reset_sync: got %b%b expected 11", hsync_out_n, vsync_out_n); end
    checks++; if (de !== 1'b0) begin failures++; $display("FAIL mid_reset_de: got %b expected 0", de); end
    checks++; if (line_len !== 10'h3FF) begin failures++; $display("FAIL mid_reset_line_len: got %0d expected 1023", line_len); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * 896) @(negedge clk);
    checks++; if (line_len !== 10'd447) begin failures++; $display("FAIL post_reset_line_len: got %0d expected 447", line_len); end
    sample_pair(c0, c1);
    checks++; if (c0 !== 9'h1FF) begin failures++; $display("FAIL post_reset_pass0: got %h expected 1ff", c0); end
    checks++; if (c1 !== {3{dim7(2)}}) begin failures++; $display("FAIL post_reset_pass1: got %h expected %h", c1, {3{dim7(2)}}); end
    dim_level = 2'd0;
  endtask

  task automatic test_bypass();
    logic [3*CW-1:0] pr;
    logic pc;
    var_pix = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    pr = {r_in, g_in, b_in}; pc = csync_in_n;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++; if ({r_out, g_out, b_out} !== pr) begin failures++; $display("FAIL bypass_colour[%0d]: got %h expected %h", i, {r_out, g_out, b_out}, pr); end
      checks++; if (hsync_out_n !== pc) begin failures++; $display("FAIL bypass_hsync[%0d]: got %b expected %b", i, hsync_out_n, pc); end
      checks++; if (vsync_out_n !== 1'b1 || de !== 1'b1) begin failures++; $display("FAIL bypass_vs_de[%0d]: got %b%b expected 11", i, vsync_out_n, de); end
      pr = {r_in, g_in, b_in}; pc = csync_in_n;
    end
    enable = 1'b1;
    var_pix = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; dim_level = 2'd0; vsync_in_n = 1'b1;
    test_reset();
    test_line_timing();
    test_glitch();
    test_dim();
    test_vsync();
    test_de();
    test_reset_midline();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
